// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter: pipeline priority, 2-entry long-latency FIFO with stale-kill
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_wb_en,
    input  logic [4:0]       pipe_wb_reg,
    input  logic [31:0]      pipe_wb_data,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [4:0]       lu_reg,
    input  logic [31:0]      lu_data,
    output logic             reg_write,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] dropped_cnt
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [4:0]  fifo_reg  [2];
    logic [31:0] fifo_data [2];
    logic [1:0]  fifo_kill;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        pipe_eff;
    logic        lu_xfer;
    logic        collide;
    logic        enq;
    logic        pop;
    logic [1:0]  ent_valid;
    logic [1:0]  kill_hit;
    logic [1:0]  drop_inc;
    logic [CNT_W:0] cnt_sum;

    // Ready depends only on registered occupancy, so a full FIFO never refills in the cycle it pops.
    assign lu_ready = (count < FULL);

    // Qualify requests, decide enqueue/pop, and find queued entries made stale by a younger pipeline write.
    always_comb begin
        pipe_eff = pipe_wb_en && (pipe_wb_reg != 5'd0);
        lu_xfer  = lu_valid && lu_ready;
        collide  = lu_xfer && pipe_eff && (lu_reg == pipe_wb_reg);
        enq      = lu_xfer && (lu_reg != 5'd0) && !collide;
        pop      = !pipe_eff && (count != 2'd0);
        for (int i = 0; i < 2; i++) begin
            ent_valid[i] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(i)));
            kill_hit[i]  = pipe_eff && ent_valid[i] && !fifo_kill[i] && (fifo_reg[i] == pipe_wb_reg);
        end
        drop_inc = {1'b0, kill_hit[0]} + {1'b0, kill_hit[1]} + {1'b0, collide};
        cnt_sum  = {1'b0, dropped_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};
    end

    // One-hot OR of every live queued destination, used by the hazard unit to stall readers.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (ent_valid[i] && !fifo_kill[i]) begin
                pending_mask[fifo_reg[i]] = 1'b1;
            end
        end
    end

    // FIFO storage, pointers, occupancy and kill flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            fifo_kill <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                fifo_reg[i]  <= 5'd0;
                fifo_data[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (kill_hit[i]) begin
                    fifo_kill[i] <= 1'b1;
                end
            end
            if (enq) begin
                fifo_reg[wr_ptr]  <= lu_reg;
                fifo_data[wr_ptr] <= lu_data;
                fifo_kill[wr_ptr] <= 1'b0;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Register-file write port: pipeline first, otherwise drain the FIFO head (killed heads are popped silently).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
        end else if (pipe_eff) begin
            reg_write  <= 1'b1;
            write_reg  <= pipe_wb_reg;
            write_data <= pipe_wb_data;
        end else if (pop && !fifo_kill[rd_ptr]) begin
            reg_write  <= 1'b1;
            write_reg  <= fifo_reg[rd_ptr];
            write_data <= fifo_data[rd_ptr];
        end else begin
            reg_write  <= 1'b0;
        end
    end

    // Saturating count of long-latency results discarded as stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_cnt <= '0;
        end else if (cnt_sum[CNT_W]) begin
            dropped_cnt <= {CNT_W{1'b1}};
        end else begin
            dropped_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
`timescale 1ns/1ps
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_reg;
    logic [31:0] pipe_wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] pending_mask;
    logic [7:0]  dropped_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [36:0] exp_q [$];
    logic [31:0] last12 = 32'd0;

    wb_arbiter #(.DEPTH(2), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_reg  (pipe_wb_reg),
        .pipe_wb_data (pipe_wb_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_reg       (lu_reg),
        .lu_data      (lu_data),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .pending_mask (pending_mask),
        .dropped_cnt  (dropped_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every write presented on the port is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (reg_write) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got reg=%0d data=%h, required no write", write_reg, write_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({write_reg, write_data} !== e) begin
                    n_bad++;
                    $display("FAIL write_order: got reg=%0d data=%h, required reg=%0d data=%h",
                             write_reg, write_data, e[36:32], e[31:0]);
                end
            end
            if (write_reg == 5'd12) last12 = write_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        pipe_wb_en   = pe;
        pipe_wb_reg  = pr;
        pipe_wb_data = pd;
        lu_valid     = lv;
        lu_reg       = lr;
        lu_data      = ld;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_dropped", {24'd0, dropped_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // pipeline only
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        expect_write(5'd5, 32'hDEADBEEF);
        tick();
        drive(1, 5'd0, 32'h11111111, 0, 0, 0);
        tick();
        check("r0_ignored", {31'd0, reg_write}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // long-latency only
        drive(0, 0, 0, 1, 5'd8, 32'h12345678);
        expect_write(5'd8, 32'h12345678);
        tick();
        check("ll_pending_after_xfer", pending_mask, 32'h100);
        check("ll_no_issue_on_enq", {31'd0, reg_write}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("ll_issue", {31'd0, reg_write}, 32'd1);
        check("ll_pending_clear", pending_mask, 32'd0);
        tick();

        // backpressure
        drive(1, 5'd3, 32'h33, 1, 5'd9, 32'h99);
        expect_write(5'd3, 32'h33);
        tick();
        drive(1, 5'd3, 32'h34, 1, 5'd10, 32'hA0);
        expect_write(5'd3, 32'h34);
        tick();
        drive(1, 5'd3, 32'h35, 0, 0, 0);
        check("bp_ready_full", {31'd0, lu_ready}, 32'd0);
        check("bp_pending", pending_mask, 32'h600);
        expect_write(5'd3, 32'h35);
        tick();
        check("bp_ready_still_full", {31'd0, lu_ready}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        expect_write(5'd9, 32'h99);
        expect_write(5'd10, 32'hA0);
        tick();
        check("bp_ready_after_pop", {31'd0, lu_ready}, 32'd1);
        check("bp_pending_one", pending_mask, 32'h400);
        tick();
        check("bp_pending_empty", pending_mask, 32'd0);
        tick();

        // stale kill
        drive(1, 5'd3, 32'h40, 1, 5'd12, 32'h1212);
        expect_write(5'd3, 32'h40);
        tick();
        check("kill_pending_before", pending_mask, 32'h1000);
        drive(1, 5'd12, 32'hAAAA, 0, 0, 0);
        expect_write(5'd12, 32'hAAAA);
        tick();
        check("kill_pending_after", pending_mask, 32'd0);
        check("kill_dropped", {24'd0, dropped_cnt}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("kill_pop_no_write", {31'd0, reg_write}, 32'd0);
        check("kill_ready_after_pop", {31'd0, lu_ready}, 32'd1);
        tick();
        check("kill_final_r12", last12, 32'hAAAA);

        // same-edge collision, then saturation
        drive(1, 5'd7, 32'h7007, 1, 5'd7, 32'h77);
        expect_write(5'd7, 32'h7007);
        tick();
        check("coll_ready", {31'd0, lu_ready}, 32'd1);
        check("coll_pending", pending_mask, 32'd0);
        check("coll_dropped", {24'd0, dropped_cnt}, 32'd2);
        for (int k = 0; k < 299; k++) begin
            expect_write(5'd7, 32'h7007);
            tick();
        end
        check("coll_saturate", {24'd0, dropped_cnt}, 32'd255);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // reset while two entries are queued
        drive(1, 5'd3, 32'h50, 1, 5'd20, 32'h2020);
        expect_write(5'd3, 32'h50);
        tick();
        drive(1, 5'd3, 32'h51, 1, 5'd21, 32'h2121);
        expect_write(5'd3, 32'h51);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("mid_pending_full", pending_mask, 32'h300000);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, lu_ready}, 32'd1);
        check("mid_rst_pending", pending_mask, 32'd0);
        check("mid_rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("mid_rst_dropped", {24'd0, dropped_cnt}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("mid_rst_pending_after", pending_mask, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter that drives the single write port of the CPU register file.
- Merges two result sources: in-order pipeline write-back from MEM/WB, and results from the long-latency unit (mul/div), which uses a valid/ready handshake.
- Pipeline results always win the port. Long-latency results queue in a 2-entry FIFO and drain in idle slots.
- Exports a pending-write mask so the hazard unit can stall readers of registers with queued writes.

Parameters:
- DEPTH, 2, FIFO entries for long-latency results; fixed at 2, pointers are 1 bit.
- CNT_W, 8, width of the saturating dropped-write counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- pipe_wb_en  in  1  pipeline write-back request; no backpressure
- pipe_wb_reg  in  5  pipeline destination register
- pipe_wb_data  in  32  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  arbiter can accept the long-latency result
- lu_reg  in  5  long-latency destination register
- lu_data  in  32  long-latency result data
- reg_write  out  1  register-file write enable (registered)
- write_reg  out  5  register-file write address (registered)
- write_data  out  32  register-file write data (registered)
- pending_mask  out  32  bit i=1 when a live FIFO entry targets register i
- dropped_cnt  out  CNT_W  count of long-latency writes discarded as stale

Behaviour:
- Reset (rst_n=0, async): FIFO emptied, all kill flags cleared, reg_write=0, write_reg=0, write_data=0, dropped_cnt=0. Consequently lu_ready=1 and pending_mask=0.
- Qualification: a pipeline request is effective when pipe_wb_en=1 and pipe_wb_reg!=0. Any write to register 0 is ignored by every path and never reaches reg_write.
- Handshake: lu_ready = (count<2), computed from registered state only, with no combinational path from lu_valid. A transfer occurs on a clock edge when lu_valid && lu_ready. The source holds reg and data stable while lu_valid=1 && lu_ready=0.
- Enqueue:
  - A transferred entry with lu_reg==0 is accepted but not enqueued.
  - A transferred entry whose lu_reg equals an effective pipe_wb_reg on the same edge is accepted, discarded, and dropped_cnt increments.
  - Otherwise the entry is enqueued with kill=0.
- Issue, per edge, priority order:
  1. Effective pipeline request: reg_write=1 with the pipeline reg/data; no FIFO pop.
  2. Else, FIFO non-empty: pop the head. If the head is live, reg_write=1 with its reg/data. If killed, reg_write=0.
  3. Else: reg_write=0; write_reg and write_data hold their last values.
- Latency:
  - Pipeline: 1 cycle from request to reg_write.
  - Long-latency: at least 2 cycles from transfer to reg_write. An entry is never issued on its enqueue edge.
- Kill rule:
  - On every effective pipeline request, each live FIFO entry with reg==pipe_wb_reg gets kill=1 and dropped_cnt increments once per entry killed.
  - Killed entries still occupy their slot until popped.
  - Rationale: the pipeline write is younger in program order, so the queued value is stale.
- Simultaneous events:
  - Enqueue and pop on the same edge are both allowed; count stays unchanged.
  - When full, lu_ready=0 even if a pop happens on that edge, so there is no same-cycle refill.
  - The kill check on an edge covers existing entries and the incoming transfer.
- pending_mask is the OR over live (non-killed) entries of a one-hot decode of their reg. It is combinational from registered FIFO state.
- dropped_cnt saturates at 2^CNT_W-1. If two increments occur on one edge, it adds 2 and still saturates.
- Reset mid-operation clears queued entries without issuing them; no write is produced after rst_n falls.
- Write ordering to the register file: for any register, the last value written equals the program-order-latest result.

Test Plan:
- Reset → reg_write=0, lu_ready=1, pending_mask=0, dropped_cnt=0. Assert rst_n=0 while two entries are queued → FIFO empties immediately, no writes afterwards.
- Pipeline only: pipe_wb_en=1, reg=5, data=0xDEADBEEF → next edge reg_write=1, write_reg=5, write_data=0xDEADBEEF. reg=0 with en=1 → reg_write=0.
- Long-latency only: transfer reg=8, data=0x12345678 on edge N → pending_mask=0x100 after N; write issued at N+1; pending_mask=0 after N+1.
- Backpressure: pipeline busy every cycle (reg=3); transfer reg=9 then reg=10 → lu_ready=0, pending_mask=0x600. Pipeline goes idle → reg 9 issued, then reg 10, in order; lu_ready returns to 1 after the first pop.
- Stale kill: queue reg=12 while the pipeline is busy, then a pipeline write to reg 12 with data 0xAAAA → entry killed, pending_mask bit 12 clears, dropped_cnt=1. The later pop produces reg_write=0; the final register-12 write is 0xAAAA.
- Same-edge collision: lu transfer reg=7 and pipeline reg=7 on the same edge → pipeline write issued, lu entry discarded, count unchanged, dropped_cnt increments. Then drive 300 such collisions → dropped_cnt saturates at 255.
